// File: rtl/mipi_raw10_ddr_packer_if.sv
// Stream bundle for the RAW10-to-DDR packer: depacker beats in, packed 128-bit words out.
// The master modport is the environment side; the slave modport is the packer itself.
interface mipi_raw10_ddr_packer_if #(
    parameter int WORD_CNT_W = 16
);
    logic [39:0]           I_Mipi_raw10_Data;
    logic                  I_Mipi_raw10_Vaild;
    logic                  I_Mipi_Sync;
    logic [127:0]          O_Pack_Data;
    logic                  O_Pack_Vaild;
    logic                  O_Pack_Sof;
    logic                  I_Pack_Ready;
    logic                  O_Overflow;
    logic [WORD_CNT_W-1:0] O_Frame_Words;

    modport master (
        output I_Mipi_raw10_Data, I_Mipi_raw10_Vaild, I_Mipi_Sync, I_Pack_Ready,
        input  O_Pack_Data, O_Pack_Vaild, O_Pack_Sof, O_Overflow, O_Frame_Words
    );

    modport slave (
        input  I_Mipi_raw10_Data, I_Mipi_raw10_Vaild, I_Mipi_Sync, I_Pack_Ready,
        output O_Pack_Data, O_Pack_Vaild, O_Pack_Sof, O_Overflow, O_Frame_Words
    );
endinterface

// File: rtl/mipi_raw10_ddr_packer.sv
// Packs four 4-pixel RAW10 beats (8 MSBs per pixel) into one 128-bit word, buffers
// words in a show-ahead FIFO and tracks SOF, per-frame word count and overflow.
module mipi_raw10_ddr_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_CNT_W = 16
) (
    input  logic                    I_CLK,
    input  logic                    I_Rst_n,
    mipi_raw10_ddr_packer_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0]            beat_cnt_q, beat_cnt_d;
    logic [95:0]           hold_q, hold_d;
    logic                  sync_q, sync_d;
    logic                  sof_pend_q, sof_pend_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [128:0]          mem_q [FIFO_DEPTH];
    logic [128:0]          mem_d [FIFO_DEPTH];
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [WORD_CNT_W-1:0] frame_words_q, frame_words_d;
    logic                  overflow_q, overflow_d;

    logic [31:0]  beat_bytes;
    logic [1:0]   cnt_eff;
    logic         frame_start;
    logic         push_try;
    logic         push_ok;
    logic         pop;
    logic         full;
    logic         empty;
    logic [127:0] word;

    always_comb begin
        beat_bytes    = {bus.I_Mipi_raw10_Data[39:32], bus.I_Mipi_raw10_Data[29:22],
                         bus.I_Mipi_raw10_Data[19:12], bus.I_Mipi_raw10_Data[9:2]};
        frame_start   = bus.I_Mipi_Sync & ~sync_q;
        // A beat arriving on the frame-start edge is beat 0 of the new frame.
        cnt_eff       = frame_start ? 2'd0 : beat_cnt_q;
        push_try      = bus.I_Mipi_raw10_Vaild & (cnt_eff == 2'd3);
        word          = {beat_bytes, hold_q};
        empty         = (wr_ptr_q == rd_ptr_q);
        full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop           = ~empty & bus.I_Pack_Ready;
        push_ok       = push_try & (~full | pop);

        sync_d        = bus.I_Mipi_Sync;
        beat_cnt_d    = cnt_eff;
        hold_d        = hold_q;
        sof_pend_d    = sof_pend_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mem_d         = mem_q;
        word_cnt_d    = word_cnt_q;
        frame_words_d = frame_words_q;
        overflow_d    = overflow_q;

        if (bus.I_Mipi_raw10_Vaild) begin
            beat_cnt_d = cnt_eff + 2'd1;
            case (cnt_eff)
                2'd0:    hold_d[31:0]  = beat_bytes;
                2'd1:    hold_d[63:32] = beat_bytes;
                2'd2:    hold_d[95:64] = beat_bytes;
                default: hold_d        = hold_q;
            endcase
        end

        if (frame_start) begin
            sof_pend_d    = 1'b1;
            frame_words_d = word_cnt_q;
            word_cnt_d    = '0;
            overflow_d    = 1'b0;
        end else if (push_try) begin
            sof_pend_d = 1'b0;
        end

        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = {sof_pend_q, word};
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (!(&word_cnt_q)) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end else if (push_try) begin
            overflow_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            beat_cnt_q    <= '0;
            hold_q        <= '0;
            sync_q        <= 1'b0;
            sof_pend_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            word_cnt_q    <= '0;
            frame_words_q <= '0;
            overflow_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            beat_cnt_q    <= beat_cnt_d;
            hold_q        <= hold_d;
            sync_q        <= sync_d;
            sof_pend_q    <= sof_pend_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            word_cnt_q    <= word_cnt_d;
            frame_words_q <= frame_words_d;
            overflow_q    <= overflow_d;
            mem_q         <= mem_d;
        end
    end

    assign bus.O_Pack_Vaild  = ~empty;
    assign bus.O_Pack_Data   = mem_q[rd_ptr_q[AW-1:0]][127:0];
    assign bus.O_Pack_Sof    = mem_q[rd_ptr_q[AW-1:0]][128];
    assign bus.O_Overflow    = overflow_q;
    assign bus.O_Frame_Words = frame_words_q;
endmodule

// File: doc/mipi_raw10_ddr_packer.md
# mipi_raw10_ddr_packer

Downstream stage of the MIPI CSI receive top. Consumes the 40-bit RAW10 depacker stream (4 pixels per beat), keeps the 8 MSBs of each pixel and packs 16 pixels into 128-bit words for the DDR3 write path. Output words pass through a small FIFO with valid/ready handshake. The block also flags the first word of each frame, counts words per frame, and reports overflow, since the upstream stream has no backpressure.

## Interface
- FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2.
- WORD_CNT_W, 16, width of the per-frame word counter.

- I_CLK  in  1  MIPI CSI byte clock; the only clock.
- I_Rst_n  in  1  asynchronous, active-low reset.
- I_Mipi_raw10_Data  in  40  four RAW10 pixels; pixel k is in [10k+9:10k], and pixel 0 is earliest.
- I_Mipi_raw10_Vaild  in  1  beat qualifier.
- I_Mipi_Sync  in  1  frame sync level from the unpacker; a rising edge marks frame start.
- O_Pack_Data  out  128  16 packed 8-bit pixels; the earliest pixel is in [7:0].
- O_Pack_Vaild  out  1  FIFO head valid.
- O_Pack_Sof  out  1  head word is the first word of a frame; qualified by O_Pack_Vaild.
- I_Pack_Ready  in  1  consumer accepts the head word when Vaild and Ready are both high.
- O_Overflow  out  1  sticky; a completed word was dropped because the FIFO was full.
- O_Frame_Words  out  WORD_CNT_W  number of words pushed during the previous frame.

## Operation
- Pixel truncation: byte k of a beat is I_Mipi_raw10_Data[10k+9:10k+2].
- Accumulator:
  - A 2-bit beat counter and a 96-bit holding register.
  - Beat n (0..3) lands in bits [32n+31:32n] of the output word.
  - On a valid beat with counter = 3, the assembled word is {beat3 bytes, holding[95:0]}. It is pushed to the FIFO and the counter wraps to 0.
- Frame start:
  - Sync is registered once; a frame start is detected when the current I_Mipi_Sync is 1 and the registered copy is 0.
  - On frame start, the beat counter is cleared and any partial word is discarded (never pushed).
  - The SOF-pending flag is set.
  - The word counter value is latched into O_Frame_Words, then the counter is cleared.
  - O_Overflow is cleared.
- Same-cycle sync and beat: if a frame-start edge and a valid beat occur in the same cycle, that beat is beat 0 of the new frame.
- FIFO:
  - Each entry is 129 bits ({sof, data}).
  - sof = SOF-pending at push time; SOF-pending is cleared on the first push attempt after frame start, even if that push is dropped.
  - The FIFO is show-ahead: the head is on O_Pack_Data and O_Pack_Sof whenever O_Pack_Vaild = 1.
  - The FIFO is not flushed at frame start; old-frame words drain normally.
- Full FIFO:
  - A push to a full FIFO is dropped and O_Overflow is set.
  - If a pop occurs in the same cycle, the FIFO is not full for that push and the push succeeds.
- Word counter: increments on each successful push and saturates at all ones. Dropped words are not counted.
- Overflow precedence: if an overflow and a frame start happen in the same cycle, O_Overflow ends that cycle set, because the drop belongs to the new frame.

## Timing
- Reset values: O_Pack_Data = 0, O_Pack_Vaild = 0, O_Pack_Sof = 0, O_Overflow = 0, O_Frame_Words = 0. Internally, the FIFO is empty, the beat counter is 0, SOF-pending is 0, and the registered sync is 0.
- Reset mid-frame discards the FIFO contents and the partial word immediately (asynchronously).
- Latency: the 4th beat is sampled at edge E, and O_Pack_Vaild with the word is visible after E (1 cycle).
- Handshake:
  - A pop happens at the edge where O_Pack_Vaild and I_Pack_Ready are both 1, and the next entry is visible after that edge.
  - O_Pack_Data and O_Pack_Sof are stable while Vaild = 1 and Ready = 0.
- Pointers are log2(FIFO_DEPTH)+1 bits wide. Full is when the MSBs differ and the LSBs are equal; empty is when the pointers are equal.
- Sustained throughput is 1 word per 4 cycles, so a consumer stalled for more than 4×FIFO_DEPTH cycles during a frame causes overflow.
- O_Frame_Words updates 1 cycle after the frame-start edge is detected; O_Overflow clears at the same edge.

## Test plan
- Packing:
  - Stimulus: frame start, then 4 valid beats where pixel value = 4×beat+k in the upper 8 bits (raw10 = value<<2 | 2'b11), with Ready held at 1.
  - Required: one word with bytes 0x00..0x0F in order from [7:0], Sof = 1, and Vaild high exactly 1 cycle after the 4th beat.
- Gapped input:
  - Stimulus: beats interleaved with Vaild = 0 cycles, 8 beats in total.
  - Required: 2 words, Sof only on the first, identical data to the gap-free case.
- Partial discard:
  - Stimulus: 2 beats, then a sync rising edge together with a valid beat, then 3 more beats.
  - Required: exactly one word, built from the edge beat and the following 3, with Sof = 1.
- Backpressure and overflow, FIFO_DEPTH = 4:
  - Stimulus: Ready = 0 while 20 beats (5 words) arrive.
  - Required: Vaild stays high and the head is unchanged; O_Overflow rises on the 5th word.
  - Then, with Ready = 1: words 1–4 drain in order, and O_Overflow stays 1 until the next frame start.
- Simultaneous push/pop at full: with the FIFO full, pop and push in the same cycle. Required: no overflow, and the FIFO is still full.
- Frame accounting: 3 frames of 40, 0 and 7 words. Required: O_Frame_Words reads 40, then 0, then 7 after the following sync edges. Also, an asynchronous reset mid-frame drops Vaild to 0 immediately.
